// File: rtl/pp_accumulator.sv
// pp_accumulator
//   Takes the partial products of one signed multiplication, sums them into a
//   PP_SIZE-bit product one term per cycle, and adds the sign-extended product
//   to an ACC_SIZE-bit accumulator. A term flagged "last" ends the dot product.
//   The result and a sticky signed-overflow flag are then presented until the
//   downstream side accepts them.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   pp_valid_i   partial-product set valid
//   pp_ready_o   set can be accepted (IDLE only)
//   pp_i         PP_PER_MUL partial products of one multiplication
//   pp_last_i    set is the final term of the dot product
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   out_o        accumulated signed result (0 while out_valid_o is low)
//   ovf_o        signed overflow seen in this group (0 while out_valid_o is low)
//   busy_o       not idle
module pp_accumulator #(
  parameter int IN_MUL_SIZE = 9,
  parameter int PP_PER_MUL  = (IN_MUL_SIZE + 2) / 3,
  parameter int PP_SIZE     = IN_MUL_SIZE * 2,
  parameter int ACC_SIZE    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pp_valid_i,
  output logic                pp_ready_o,
  input  logic [PP_SIZE-1:0]  pp_i [0:PP_PER_MUL-1],
  input  logic                pp_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] out_o,
  output logic                ovf_o,
  output logic                busy_o
);

  localparam int IDX_W = (PP_PER_MUL > 1) ? $clog2(PP_PER_MUL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PP_PER_MUL - 1);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t              state_q, state_d;
  logic [PP_SIZE-1:0]  pp_q [0:PP_PER_MUL-1];
  logic                last_q;
  logic [PP_SIZE-1:0]  prod_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ACC_SIZE-1:0] acc_q;
  logic                ovf_q;
  logic                ready_en_q;

  logic [ACC_SIZE-1:0] prod_ext;
  logic [ACC_SIZE-1:0] acc_sum;
  logic                ovf_step;
  logic                take_in;

  // Size cast of a signed operand sign-extends; also valid when ACC_SIZE == PP_SIZE.
  assign prod_ext = ACC_SIZE'($signed(prod_q));
  assign acc_sum  = acc_q + prod_ext;
  assign ovf_step = (acc_q[ACC_SIZE-1] == prod_ext[ACC_SIZE-1]) &&
                    (acc_sum[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);

  // ready_en_q holds pp_ready_o low until the first edge after reset release.
  assign pp_ready_o  = (state_q == IDLE) && ready_en_q;
  assign take_in     = pp_valid_i && pp_ready_o;
  assign out_valid_o = (state_q == OUTPUT);
  assign out_o       = out_valid_o ? acc_q : '0;
  assign ovf_o       = out_valid_o && ovf_q;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take_in) state_d = REDUCE;
      REDUCE:  if (idx_q == IDX_LAST) state_d = ACCUM;
      ACCUM:   state_d = last_q ? OUTPUT : IDLE;
      OUTPUT:  if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      last_q     <= 1'b0;
      prod_q     <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i < PP_PER_MUL; i++) pp_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (take_in) begin
            pp_q   <= pp_i;
            last_q <= pp_last_i;
            prod_q <= '0;
            idx_q  <= '0;
          end
        end
        REDUCE: begin
          prod_q <= prod_q + pp_q[idx_q];
          idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        ACCUM: begin
          acc_q <= acc_sum;
          if (ovf_step) ovf_q <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
module tb_pp_accumulator;

  localparam int P = 3;
  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default-parameter instance
  logic          pv, pr, plast, ov, ordy, ovf, busy;
  logic [W-1:0]  pp [0:P-1];
  logic [31:0]   out;

  // ACC_SIZE = 18 instance
  logic          pv2, pr2, plast2, ov2, ordy2, ovf2, busy2;
  logic [W-1:0]  pp2 [0:P-1];
  logic [17:0]   out2;

  int asserts = 0;
  int fails   = 0;

  longint m_acc, m18_acc;
  bit     m_ovf, m18_ovf;

  pp_accumulator dut (
    .clk_i(clk), .rst_ni(rst_n), .pp_valid_i(pv), .pp_ready_o(pr), .pp_i(pp),
    .pp_last_i(plast), .out_valid_o(ov), .out_ready_i(ordy), .out_o(out),
    .ovf_o(ovf), .busy_o(busy)
  );

  pp_accumulator #(.ACC_SIZE(18)) dut18 (
    .clk_i(clk), .rst_ni(rst_n), .pp_valid_i(pv2), .pp_ready_o(pr2), .pp_i(pp2),
    .pp_last_i(plast2), .out_valid_o(ov2), .out_ready_i(ordy2), .out_o(out2),
    .ovf_o(ovf2), .busy_o(busy2)
  );

  // Reference model: plain signed integer arithmetic with explicit wrapping.
  function automatic longint wrap_s(input longint v, input int n);
    longint m, r;
    m = longint'(1) << n;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint prod_of(input logic [W-1:0] a, b, c);
    return wrap_s(longint'(a) + longint'(b) + longint'(c), W);
  endfunction

  task automatic acc_step(inout longint acc, inout bit ov_f, input longint p, input int n);
    longint t, lim;
    t   = acc + p;
    lim = longint'(1) << (n - 1);
    if (t > lim - 1 || t < -lim) ov_f = 1'b1;
    acc = wrap_s(t, n);
  endtask

  task automatic send(input logic [W-1:0] a, b, c, input logic last, input int hold_in,
                      input bit chk, input logic [31:0] exp_out, input string nm);
    int n, hold;
    bit bad;
    logic [31:0] held_out, mexp;
    logic held_ovf;
    n = 0;
    while (!pr && n < 50) begin @(posedge clk); #1; n++; end
    asserts++;
    if (!pr) begin
      fails++;
      $display("FAIL %s ready_timeout: pp_ready=%b required 1", nm, pr);
      return;
    end
    pv = 1'b1; pp[0] = a; pp[1] = b; pp[2] = c; plast = last;
    @(posedge clk); #1;
    acc_step(m_acc, m_ovf, prod_of(a, b, c), 32);
    asserts++;
    if (busy !== 1'b1 || pr !== 1'b0) begin
      fails++;
      $display("FAIL %s accept: busy=%b pp_ready=%b required busy=1 pp_ready=0", nm, busy, pr);
    end
    n = 0; bad = 0;
    while (!(last ? ov : pr) && n < 20) begin
      // garbage offered while busy must be ignored
      pv = 1'($urandom); pp[0] = W'($urandom); pp[1] = W'($urandom);
      pp[2] = W'($urandom); plast = 1'($urandom);
      @(posedge clk); #1; n++;
      if (!last && ov) bad = 1;
      if (!ov && (out !== '0 || ovf !== 1'b0)) bad = 1;
    end
    pv = 1'b0;
    asserts++;
    if (n != P + 1) begin
      fails++;
      $display("FAIL %s latency: edges=%0d required %0d", nm, n, P + 1);
    end
    asserts++;
    if (bad) begin
      fails++;
      $display("FAIL %s quiet_outputs: out_valid/out/ovf active before result (bad=%0d) required 0", nm, bad);
    end
    if (last) begin
      mexp = m_acc[31:0];
      asserts++;
      if (out !== mexp || ovf !== m_ovf) begin
        fails++;
        $display("FAIL %s result: out=%h ovf=%b required out=%h ovf=%b", nm, out, ovf, mexp, m_ovf);
      end
      if (chk) begin
        asserts++;
        if (out !== exp_out) begin
          fails++;
          $display("FAIL %s const_result: out=%h required %h", nm, out, exp_out);
        end
      end
      held_out = out; held_ovf = ovf; bad = 0;
      hold = (hold_in < 0) ? int'($urandom_range(0, 3)) : hold_in;
      for (int i = 0; i < hold; i++) begin
        pv = 1'b1; pp[0] = W'($urandom);
        @(posedge clk); #1;
        if (!ov || out !== held_out || ovf !== held_ovf || pr || !busy) bad = 1;
      end
      pv = 1'b0;
      asserts++;
      if (bad) begin
        fails++;
        $display("FAIL %s backpressure: out=%h ovf=%b pp_ready=%b required out=%h ovf=%b pp_ready=0",
                 nm, out, ovf, pr, held_out, held_ovf);
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      asserts++;
      if (ov !== 1'b0 || out !== '0 || ovf !== 1'b0 || pr !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL %s drain: out_valid=%b out=%h ovf=%b pp_ready=%b busy=%b required 0,0,0,1,0",
                 nm, ov, out, ovf, pr, busy);
      end
      m_acc = 0; m_ovf = 0;
    end
  endtask

  task automatic send18(input logic [W-1:0] a, b, c, input logic last, input bit chk,
                        input logic [17:0] exp_out, input logic exp_ovf, input string nm);
    int n;
    logic [17:0] mexp;
    n = 0;
    while (!pr2 && n < 50) begin @(posedge clk); #1; n++; end
    asserts++;
    if (!pr2) begin
      fails++;
      $display("FAIL %s ready_timeout: pp_ready=%b required 1", nm, pr2);
      return;
    end
    pv2 = 1'b1; pp2[0] = a; pp2[1] = b; pp2[2] = c; plast2 = last;
    @(posedge clk); #1;
    pv2 = 1'b0;
    acc_step(m18_acc, m18_ovf, prod_of(a, b, c), 18);
    n = 0;
    while (!(last ? ov2 : pr2) && n < 20) begin @(posedge clk); #1; n++; end
    asserts++;
    if (n != P + 1) begin
      fails++;
      $display("FAIL %s latency: edges=%0d required %0d", nm, n, P + 1);
    end
    if (last) begin
      mexp = m18_acc[17:0];
      asserts++;
      if (out2 !== mexp || ovf2 !== m18_ovf) begin
        fails++;
        $display("FAIL %s result: out=%h ovf=%b required out=%h ovf=%b", nm, out2, ovf2, mexp, m18_ovf);
      end
      if (chk) begin
        asserts++;
        if (out2 !== exp_out || ovf2 !== exp_ovf) begin
          fails++;
          $display("FAIL %s const_result: out=%h ovf=%b required out=%h ovf=%b",
                   nm, out2, ovf2, exp_out, exp_ovf);
        end
      end
      ordy2 = 1'b1;
      @(posedge clk); #1;
      ordy2 = 1'b0;
      m18_acc = 0; m18_ovf = 0;
    end
  endtask

  task automatic test_reset();
    #2;
    asserts++;
    if (pr || ov || out !== '0 || ovf || busy || pr2 || ov2 || out2 !== '0 || ovf2 || busy2) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b out=%h ovf=%b busy=%b required all 0",
               pr, ov, out, ovf, busy);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    asserts++;
    if (pr !== 1'b0 || pr2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready: pp_ready=%b/%b required 0 before first edge", pr, pr2);
    end
    @(posedge clk); #1;
    asserts++;
    if (pr !== 1'b1 || pr2 !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_edge_ready: pp_ready=%b/%b busy=%b required 1/1 busy=0", pr, pr2, busy);
    end
  endtask

  task automatic test_single();
    send(18'd5, 18'd7, 18'h3FFFF, 1'b1, 0, 1'b1, 32'd11, "single");
  endtask

  task automatic test_dot_product();
    send(18'd6, 18'd0, 18'd0, 1'b0, 0, 1'b0, '0, "dot_t0");
    send(18'h3FFFC, 18'd0, 18'd0, 1'b0, 0, 1'b0, '0, "dot_t1");
    send(18'd3, 18'd3, 18'd4, 1'b1, 0, 1'b1, 32'd12, "dot_t2");
  endtask

  task automatic test_wrap();
    send(18'h20000, 18'h20000, 18'd0, 1'b1, 0, 1'b1, 32'd0, "product_wrap");
  endtask

  task automatic test_backpressure();
    send(18'h3FF00, 18'd17, 18'd2, 1'b1, 3, 1'b1, 32'hFFFF_FF13, "backpressure");
  endtask

  task automatic test_overflow();
    send18(18'h1FFFF, 18'd0, 18'd0, 1'b0, 1'b0, '0, 1'b0, "ovf_t0");
    send18(18'h1FFFF, 18'd0, 18'd0, 1'b1, 1'b1, 18'h3FFFE, 1'b1, "ovf_t1");
    send18(18'd5, 18'd0, 18'd0, 1'b1, 1'b1, 18'd5, 1'b0, "ovf_next_group");
  endtask

  task automatic test_reset_mid_reduce();
    int n;
    bit pulse;
    n = 0;
    while (!pr && n < 50) begin @(posedge clk); #1; n++; end
    pv = 1'b1; pp[0] = 18'd9; pp[1] = 18'd9; pp[2] = 18'd9; plast = 1'b1;
    @(posedge clk); #1;
    pv = 1'b0;
    @(posedge clk); #1;
    asserts++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_reduce_busy: busy=%b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if (pr || ov || out !== '0 || ovf || busy) begin
      fails++;
      $display("FAIL mid_reduce_reset: ready=%b valid=%b out=%h ovf=%b busy=%b required all 0",
               pr, ov, out, ovf, busy);
    end
    rst_n = 1'b1;
    m_acc = 0; m_ovf = 0; m18_acc = 0; m18_ovf = 0;
    pulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov || ov2) pulse = 1;
    end
    asserts++;
    if (pulse) begin
      fails++;
      $display("FAIL mid_reduce_no_pulse: out_valid pulsed=%b required 0", pulse);
    end
    send(18'd1, 18'd0, 18'd0, 1'b1, 0, 1'b1, 32'd1, "after_reset_single");
  endtask

  task automatic test_random();
    int nt;
    for (int g = 0; g < 20; g++) begin
      nt = int'($urandom_range(1, 4));
      for (int t = 0; t < nt; t++)
        send(W'($urandom), W'($urandom), W'($urandom), (t == nt - 1), -1, 1'b0, '0, "random");
    end
    for (int g = 0; g < 6; g++) begin
      nt = int'($urandom_range(1, 3));
      for (int t = 0; t < nt; t++)
        send18(W'($urandom), W'($urandom), W'($urandom), (t == nt - 1), 1'b0, '0, 1'b0, "random18");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pv = 1'b0; plast = 1'b0; ordy = 1'b0;
    pv2 = 1'b0; plast2 = 1'b0; ordy2 = 1'b0;
    for (int i = 0; i < P; i++) begin pp[i] = '0; pp2[i] = '0; end
    m_acc = 0; m_ovf = 0; m18_acc = 0; m18_ovf = 0;

    test_reset();
    test_single();
    test_dot_product();
    test_wrap();
    test_backpressure();
    test_overflow();
    test_reset_mid_reduce();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
